// File: rtl/bitwise_cmd_queue.sv
// ---------------------------------------------------------------------------
// BitwiseCmdQueue (module bitwise_cmd_queue)
//
// Purpose:
//   Small command FIFO that sits in front of bitwise_operations. A valid/ready
//   producer pushes {a, b, op} commands. At most one command is issued per
//   clock onto registered a/b/op outputs, which drive bitwise_operations
//   directly. issue_valid flags the cycle after a fresh command was loaded.
//   stall holds issuing while the downstream is busy. Pushes keep landing
//   until the queue is full.
//
// Ports:
//   clk          in   clock, every register updates on the rising edge
//   rst_n        in   asynchronous active-low reset
//   in_valid     in   producer has a command this cycle
//   in_ready     out  queue can accept a command (not full)
//   in_a/in_b    in   command operands, WIDTH bits each
//   in_op        in   2-bit opcode, carried through untouched
//   stall        in   1 = hold issue this cycle
//   a/b/op       out  last issued command, held while idle
//   issue_valid  out  1 = a/b/op were loaded at the last edge
//   count        out  number of entries currently queued
//   issue_count  out  running total of issued commands, wraps silently
// ---------------------------------------------------------------------------
module bitwise_cmd_queue #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [WIDTH-1:0]           in_b,
    input  logic [1:0]                 in_op,
    input  logic                       stall,
    output logic [WIDTH-1:0]           a,
    output logic [WIDTH-1:0]           b,
    output logic [1:0]                 op,
    output logic                       issue_valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic [CNT_W-1:0]           issue_count
);

    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_BITS = PTR_W + 1;

    // Command storage, one slot per entry.
    logic [WIDTH-1:0]    memA  [DEPTH];
    logic [WIDTH-1:0]    memB  [DEPTH];
    logic [1:0]          memOp [DEPTH];

    logic [PTR_W-1:0]    wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]    rdPtr_q, rdPtr_d;
    logic [CNT_BITS-1:0] count_q, count_d;
    logic [WIDTH-1:0]    a_q, a_d;
    logic [WIDTH-1:0]    b_q, b_d;
    logic [1:0]          op_q, op_d;
    logic                issueValid_q, issueValid_d;
    logic [CNT_W-1:0]    issueCount_q, issueCount_d;

    logic                doPush;
    logic                doPop;

    // Full is decided from the registered occupancy only, so in_ready has no
    // combinational dependence on in_valid or stall. A pop at the same edge
    // does not open a slot for a push; in_ready rises on the following cycle.
    assign in_ready = (count_q != CNT_BITS'(DEPTH));
    assign doPush   = in_valid && in_ready;
    assign doPop    = (count_q != '0) && !stall;

    // Next-state logic. DEPTH is a power of two, so the pointers wrap
    // naturally; count alone distinguishes full from empty. Issued operands
    // hold their last value whenever nothing is popped.
    always_comb begin
        wrPtr_d      = wrPtr_q;
        rdPtr_d      = rdPtr_q;
        count_d      = count_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        issueValid_d = 1'b0;
        issueCount_d = issueCount_q;

        if (doPush) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end

        if (doPop) begin
            rdPtr_d      = rdPtr_q + 1'b1;
            a_d          = memA[rdPtr_q];
            b_d          = memB[rdPtr_q];
            op_d         = memOp[rdPtr_q];
            issueValid_d = 1'b1;
            issueCount_d = issueCount_q + 1'b1;
        end

        case ({doPush, doPop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control and issue registers. Reset empties the queue by clearing the
    // pointers and count; any stale slot contents become unreachable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q      <= '0;
            rdPtr_q      <= '0;
            count_q      <= '0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            issueValid_q <= 1'b0;
            issueCount_q <= '0;
        end else begin
            wrPtr_q      <= wrPtr_d;
            rdPtr_q      <= rdPtr_d;
            count_q      <= count_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            issueValid_q <= issueValid_d;
            issueCount_q <= issueCount_d;
        end
    end

    // Storage array has no reset; occupancy guards every read, so an entry
    // is only ever read after it has been written.
    always_ff @(posedge clk) begin
        if (doPush) begin
            memA[wrPtr_q]  <= in_a;
            memB[wrPtr_q]  <= in_b;
            memOp[wrPtr_q] <= in_op;
        end
    end

    assign a           = a_q;
    assign b           = b_q;
    assign op          = op_q;
    assign issue_valid = issueValid_q;
    assign count       = count_q;
    assign issue_count = issueCount_q;

endmodule

// File: tb/tb_bitwise_cmd_queue.sv
// ---------------------------------------------------------------------------
// TbBitwiseCmdQueue (module tb_bitwise_cmd_queue)
//
// Purpose:
//   Self-checking bench for bitwise_cmd_queue. A table of directed vectors
//   covers single issue, fill/refuse, and concurrent push+pop. Hand-written
//   sequences cover asynchronous reset and a pointer-wrap stream, and a
//   randomized phase is compared against a queue-based reference model.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_bitwise_cmd_queue;

    localparam int WIDTH = 7;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [1:0]       in_op;
    logic             stall;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             issue_valid;
    logic [2:0]       count;
    logic [CNT_W-1:0] issue_count;

    int total = 0;
    int bad   = 0;

    bitwise_cmd_queue #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_a(in_a),
        .in_b(in_b),
        .in_op(in_op),
        .stall(stall),
        .a(a),
        .b(b),
        .op(op),
        .issue_valid(issue_valid),
        .count(count),
        .issue_count(issue_count)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int a;
        int b;
        int op;
    } cmd_t;

    typedef struct {
        int v;
        int a;
        int b;
        int op;
        int st;
        int eA;
        int eB;
        int eOp;
        int eV;
        int eC;
        int eR;
        int eI;
    } vec_t;

    // Reference model: a plain queue of commands plus the last issued one.
    cmd_t mq[$];
    int   mA;
    int   mB;
    int   mOp;
    int   mV;
    int   mI;

    // Reset the model alongside the DUT.
    task automatic modelReset();
        mq.delete();
        mA  = 0;
        mB  = 0;
        mOp = 0;
        mV  = 0;
        mI  = 0;
    endtask

    // One clock of the model: decisions use the occupancy before the edge.
    task automatic modelStep(input int v, input int ca, input int cb, input int cop, input int st);
        cmd_t c;
        bit   canPush;
        bit   canPop;
        canPush = (v != 0) && (mq.size() < DEPTH);
        canPop  = (mq.size() > 0) && (st == 0);
        mV = 0;
        if (canPop) begin
            c   = mq.pop_front();
            mA  = c.a;
            mB  = c.b;
            mOp = c.op;
            mV  = 1;
            mI  = mI + 1;
        end
        if (canPush) begin
            c.a  = ca;
            c.b  = cb;
            c.op = cop;
            mq.push_back(c);
        end
    endtask

    // Drive one cycle of inputs, clock it, and advance the model.
    task automatic applyStimulus(input int v, input int ca, input int cb, input int cop, input int st);
        in_valid = 1'(v);
        in_a     = WIDTH'(ca);
        in_b     = WIDTH'(cb);
        in_op    = 2'(cop);
        stall    = 1'(st);
        @(posedge clk);
        #1;
        modelStep(v, ca, cb, cop, st);
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Compare every DUT output against one set of expected values.
    task automatic checkOutput(input string tag, input int eA, input int eB, input int eOp,
                               input int eV, input int eC, input int eR, input int eI);
        check({tag, ".a"},           int'(a),           eA);
        check({tag, ".b"},           int'(b),           eB);
        check({tag, ".op"},          int'(op),          eOp);
        check({tag, ".issue_valid"}, int'(issue_valid), eV);
        check({tag, ".count"},       int'(count),       eC);
        check({tag, ".in_ready"},    int'(in_ready),    eR);
        check({tag, ".issue_count"}, int'(issue_count), eI % (1 << CNT_W));
    endtask

    vec_t vec[$];
    cmd_t sent[$];
    cmd_t got[$];

    initial begin
        cmd_t c;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        in_op    = '0;
        stall    = 1'b0;
        modelReset();

        // Directed table: single issue, fill past full, drain in order,
        // then push+pop on the same edge at count 2.
        //             v  a     b     op st  eA    eB    eOp eV eC eR eI
        vec.push_back('{1, 'h55, 'h2A, 2, 0, 'h00, 'h00, 0, 0, 1, 1, 0});
        vec.push_back('{0, 0,    0,    0, 0, 'h55, 'h2A, 2, 1, 0, 1, 1});
        vec.push_back('{0, 0,    0,    0, 0, 'h55, 'h2A, 2, 0, 0, 1, 1});
        vec.push_back('{1, 'h01, 'h02, 0, 1, 'h55, 'h2A, 2, 0, 1, 1, 1});
        vec.push_back('{1, 'h03, 'h04, 1, 1, 'h55, 'h2A, 2, 0, 2, 1, 1});
        vec.push_back('{1, 'h05, 'h06, 2, 1, 'h55, 'h2A, 2, 0, 3, 1, 1});
        vec.push_back('{1, 'h07, 'h08, 3, 1, 'h55, 'h2A, 2, 0, 4, 0, 1});
        vec.push_back('{1, 'h09, 'h0A, 0, 1, 'h55, 'h2A, 2, 0, 4, 0, 1});
        vec.push_back('{0, 0,    0,    0, 0, 'h01, 'h02, 0, 1, 3, 1, 2});
        vec.push_back('{0, 0,    0,    0, 0, 'h03, 'h04, 1, 1, 2, 1, 3});
        vec.push_back('{0, 0,    0,    0, 0, 'h05, 'h06, 2, 1, 1, 1, 4});
        vec.push_back('{0, 0,    0,    0, 0, 'h07, 'h08, 3, 1, 0, 1, 5});
        vec.push_back('{0, 0,    0,    0, 0, 'h07, 'h08, 3, 0, 0, 1, 5});
        vec.push_back('{1, 'h11, 'h12, 1, 1, 'h07, 'h08, 3, 0, 1, 1, 5});
        vec.push_back('{1, 'h13, 'h14, 2, 1, 'h07, 'h08, 3, 0, 2, 1, 5});
        vec.push_back('{1, 'h15, 'h16, 3, 0, 'h11, 'h12, 1, 1, 2, 1, 6});
        vec.push_back('{0, 0,    0,    0, 0, 'h13, 'h14, 2, 1, 1, 1, 7});
        vec.push_back('{0, 0,    0,    0, 0, 'h15, 'h16, 3, 1, 0, 1, 8});

        // Reset state while rst_n is still low.
        #12;
        checkOutput("reset", 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vec[i]) begin
            applyStimulus(vec[i].v, vec[i].a, vec[i].b, vec[i].op, vec[i].st);
            checkOutput($sformatf("row%0d", i), vec[i].eA, vec[i].eB, vec[i].eOp,
                        vec[i].eV, vec[i].eC, vec[i].eR, vec[i].eI);
        end

        // Reset mid-operation: queue three commands under stall, then drop
        // rst_n between edges and confirm the queued entries are discarded.
        applyStimulus(1, 'h21, 'h22, 1, 1);
        applyStimulus(1, 'h23, 'h24, 2, 1);
        applyStimulus(1, 'h25, 'h26, 3, 1);
        checkOutput("preReset", 'h15, 'h16, 3, 0, 3, 1, 8);
        in_valid = 1'b0;
        stall    = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("asyncReset", 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 0);
            checkOutput($sformatf("postReset%0d", i), 0, 0, 0, 0, 0, 1, 0);
        end

        // Stream ten commands back to back so both pointers wrap, then
        // compare the issued sequence against the pushed sequence.
        for (int i = 0; i < 11; i++) begin
            if (i < 10) begin
                c.a  = int'($urandom_range((1 << WIDTH) - 1));
                c.b  = int'($urandom_range((1 << WIDTH) - 1));
                c.op = i % 4;
                sent.push_back(c);
                applyStimulus(1, c.a, c.b, c.op, 0);
            end else begin
                applyStimulus(0, 0, 0, 0, 0);
            end
            if (issue_valid) begin
                c.a  = int'(a);
                c.b  = int'(b);
                c.op = int'(op);
                got.push_back(c);
            end
        end
        check("wrap.issued", got.size(), 10);
        check("wrap.issue_count", int'(issue_count), 10);
        for (int i = 0; i < 10; i++) begin
            if (i < got.size()) begin
                check($sformatf("wrap%0d.a", i),  got[i].a,  sent[i].a);
                check($sformatf("wrap%0d.b", i),  got[i].b,  sent[i].b);
                check($sformatf("wrap%0d.op", i), got[i].op, sent[i].op);
            end
        end

        // Randomized traffic against the model; long enough for issue_count
        // to wrap past 2^CNT_W.
        for (int i = 0; i < 800; i++) begin
            applyStimulus(($urandom_range(3) != 0) ? 1 : 0,
                          int'($urandom_range((1 << WIDTH) - 1)),
                          int'($urandom_range((1 << WIDTH) - 1)),
                          int'($urandom_range(3)),
                          ($urandom_range(3) == 0) ? 1 : 0);
            checkOutput($sformatf("rand%0d", i), mA, mB, mOp, mV, mq.size(),
                        (mq.size() < DEPTH) ? 1 : 0, mI);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
